uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx serializer among N_CH byte-stream requesters.
//  Round-robin, frame-granular arbitration with packet lock (ch_last) and burst cap.
//  Drives the uart_tx FIFO-side interface, relays per-channel aborts and runs a frame
//  watchdog. Reports a per-frame completion or error pulse to the owning channel.
// PARAMETERS
//  N_CH         4      number of requester channels (2..16)
//  DATA_WIDTH   8      byte width; must match uart_tx
//  MAX_BURST    16     max frames per grant before forced release (>=1)
//  WDOG_CYCLES  65535  max clk cycles in WAIT_DONE before forced abort
//  GUARD_CYCLES 2      post-frame cycles to collect uart_tx error pulses (>=2)
// PORTS
//  clk            in   1              single clock; all logic on posedge
//  rst            in   1              synchronous, active-high reset
//  ch_valid       in   N_CH           channel i has a byte; held until ch_pop[i]
//  ch_data        in   N_CH*DATA_WIDTH  channel i byte at [i*DATA_WIDTH +: DATA_WIDTH]
//  ch_last        in   N_CH           byte is last of packet (releases lock)
//  ch_abort       in   N_CH           abort request; acted on only when channel granted
//  ch_pop         out  N_CH           1-cycle pulse: byte consumed by uart_tx
//  ch_done        out  N_CH           1-cycle pulse: frame finished cleanly
//  ch_err         out  N_CH           1-cycle pulse: frame aborted/errored/timed out
//  tx_data_in     out  DATA_WIDTH     to uart_tx data_in
//  tx_data_valid  out  1              to uart_tx data_valid
//  tx_fifo_empty  out  1              to uart_tx fifo_empty
//  tx_abort       out  1              to uart_tx abort_tx
//  tx_data_read   in   1              from uart_tx data_read
//  tx_busy        in   1              from uart_tx tx_busy
//  tx_error       in   1              from uart_tx tx_error
//  tx_underrun    in   1              from uart_tx tx_underrun
//  gnt_valid      out  1              a channel holds the grant
//  gnt_id         out  $clog2(N_CH)   granted channel index
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, gnt_id=0, burst_cnt=0, wdog=0, err_flag=0.
//   All outputs 0 except tx_fifo_empty=1. Reset mid-frame drops everything; no pulses.
//  FSM states: IDLE, SEND, WAIT_DONE, ABORT, GUARD.
//  IDLE: if |ch_valid, grant = first valid index scanning from rr_ptr upward (mod N_CH).
//   Register grant and go SEND next cycle (1-cycle arbitration latency). burst_cnt=0.
//  SEND: tx_data_valid=1, tx_data_in=ch_data[gnt].
//   ch_abort[gnt] takes priority -> ABORT.
//   On tx_data_read=1: ch_pop[gnt]=1 that cycle, latch last_q=ch_last[gnt],
//   clear wdog, go WAIT_DONE.
//  WAIT_DONE: tx_data_valid=0, wdog++ per cycle.
//   ch_abort[gnt] -> ABORT.
//   wdog==WDOG_CYCLES-1 -> ABORT.
//   tx_busy==0 -> GUARD.
//  ABORT: tx_abort=1 and err_flag=1. Stay while tx_busy==1 and for at least 1 cycle.
//   Then tx_abort=0 and go GUARD.
//  GUARD: GUARD_CYCLES cycles, no TX stimulus. On exit, exactly one of ch_done[gnt]
//   or ch_err[gnt] pulses (ch_err if err_flag), then err_flag clears.
//   Continue (-> SEND, same gnt, burst_cnt++) only if !err_flag, !last_q,
//   burst_cnt<MAX_BURST-1 and ch_valid[gnt]=1.
//   Otherwise release: rr_ptr=gnt+1 (wraps N_CH-1 -> 0), go IDLE.
//  err_flag is set on tx_error or tx_underrun sampled in any state except IDLE.
//  tx_fifo_empty = ~|ch_valid in IDLE, else 0 (never underruns an in-flight frame).
//  gnt_valid = (state != IDLE); gnt_id is held stable for the whole grant.
//  Simultaneous: tx_data_read and ch_abort[gnt] in the same SEND cycle -> pop occurs,
//   then ABORT.
//  Abort on a non-granted channel is ignored; rr_ptr only advances on release.
//  Upstream contract: ch_valid must not drop before ch_pop; violations are undefined.
// TESTING
//  T1 ch1 valid 0xA5, last=1, rest idle -> gnt_id=1 one cycle later; pop on data_read;
//     tx line 0,1,0,1,0,0,1,0,1 (LSB first, stop); ch_done[1]; rr_ptr=2.
//  T2 ch0..3 valid at once, single-byte packets -> grant order 0,1,2,3,0.
//     Each gets one frame; no channel starved.
//  T3 ch2 sends 20 bytes, last on byte 20, MAX_BURST=16 -> 16 frames then release.
//     Other pending channels served, then ch2 resumes for the remaining 4.
//  T4 ch_abort[3] asserted mid-DATA of ch3 frame -> tx_abort until tx_busy=0.
//     ch_err[3] pulses, no ch_done[3], grant released, tx idles high.
//  T5 tx_busy forced high, WDOG_CYCLES=100 -> ABORT entered at wdog=99; ch_err pulse.
//  T6 rst=1 during WAIT_DONE -> next cycle all outputs at reset values.
//     After rst=0 arbitration restarts at ch0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer among N_CH byte-stream requesters.
// Round-robin, frame-granular grants with packet lock, burst cap, abort relay and watchdog.
module uart_tx_arbiter #(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned WDOG_CYCLES  = 65535,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N_CH-1:0]              ch_valid_i,
    input  logic [N_CH*DATA_WIDTH-1:0]   ch_data_i,
    input  logic [N_CH-1:0]              ch_last_i,
    input  logic [N_CH-1:0]              ch_abort_i,
    output logic [N_CH-1:0]              ch_pop_o,
    output logic [N_CH-1:0]              ch_done_o,
    output logic [N_CH-1:0]              ch_err_o,
    output logic [DATA_WIDTH-1:0]        tx_data_in_o,
    output logic                         tx_data_valid_o,
    output logic                         tx_fifo_empty_o,
    output logic                         tx_abort_o,
    input  logic                         tx_data_read_i,
    input  logic                         tx_busy_i,
    input  logic                         tx_error_i,
    input  logic                         tx_underrun_i,
    output logic                         gnt_valid_o,
    output logic [$clog2(N_CH)-1:0]      gnt_id_o
);

    localparam int unsigned GID_W   = $clog2(N_CH);
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
    localparam int unsigned WDOG_W  = $clog2(WDOG_CYCLES + 1);
    localparam int unsigned GUARD_W = $clog2(GUARD_CYCLES + 1);

    localparam logic [GID_W-1:0]   GID_LAST   = GID_W'(N_CH - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [WDOG_W-1:0]  WDOG_LAST  = WDOG_W'(WDOG_CYCLES - 1);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_DONE,
        S_ABORT,
        S_GUARD
    } state_e;

    state_e              state_q, state_d;
    logic [GID_W-1:0]    gnt_q, gnt_d;
    logic [GID_W-1:0]    rr_q, rr_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic [GUARD_W-1:0]  guard_q, guard_d;
    logic                err_q, err_d;
    logic                last_q, last_d;
    logic [N_CH-1:0]     done_q, done_d;
    logic [N_CH-1:0]     errp_q, errp_d;

    logic                abort_gnt;
    logic                err_now;
    logic [N_CH-1:0]     gnt_onehot;

    // First valid channel at or above ptr, wrapping modulo N_CH.
    function automatic logic [GID_W-1:0] rr_pick(input logic [N_CH-1:0] v,
                                                 input logic [GID_W-1:0] ptr);
        logic [GID_W-1:0] sel;
        logic             found;
        int unsigned      idx;
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            idx = (32'(ptr) + i) % N_CH;
            if (!found && v[GID_W'(idx)]) begin
                sel   = GID_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign abort_gnt  = ch_abort_i[gnt_q];
    assign gnt_onehot = N_CH'(1) << gnt_q;
    assign err_now    = err_q | ((state_q != S_IDLE) & (tx_error_i | tx_underrun_i));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        wdog_d  = wdog_q;
        guard_d = guard_q;
        last_d  = last_q;
        err_d   = err_now;
        done_d  = '0;
        errp_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (|ch_valid_i) begin
                    gnt_d   = rr_pick(ch_valid_i, rr_q);
                    burst_d = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                // A pop in the same cycle as an abort is still honoured.
                if (tx_data_read_i) begin
                    last_d  = ch_last_i[gnt_q];
                    wdog_d  = '0;
                    state_d = abort_gnt ? S_ABORT : S_WAIT_DONE;
                end else if (abort_gnt) begin
                    state_d = S_ABORT;
                end
            end
            S_WAIT_DONE: begin
                wdog_d = wdog_q + WDOG_W'(1);
                if (abort_gnt || (wdog_q == WDOG_LAST)) begin
                    state_d = S_ABORT;
                end else if (!tx_busy_i) begin
                    guard_d = '0;
                    state_d = S_GUARD;
                end
            end
            S_ABORT: begin
                err_d = 1'b1;
                if (!tx_busy_i) begin
                    guard_d = '0;
                    state_d = S_GUARD;
                end
            end
            S_GUARD: begin
                guard_d = guard_q + GUARD_W'(1);
                if (guard_q == GUARD_LAST) begin
                    if (err_now) errp_d = gnt_onehot;
                    else         done_d = gnt_onehot;
                    err_d = 1'b0;
                    if (!err_now && !last_q && (burst_q < BURST_LAST) && ch_valid_i[gnt_q]) begin
                        burst_d = burst_q + BURST_W'(1);
                        state_d = S_SEND;
                    end else begin
                        rr_d    = (gnt_q == GID_LAST) ? '0 : gnt_q + GID_W'(1);
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            burst_q <= '0;
            wdog_q  <= '0;
            guard_q <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= '0;
            errp_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
            wdog_q  <= wdog_d;
            guard_q <= guard_d;
            err_q   <= err_d;
            last_q  <= last_d;
            done_q  <= done_d;
            errp_q  <= errp_d;
        end
    end

    // Pop must coincide with the serializer's read strobe, so it is decoded in-cycle.
    assign ch_pop_o        = (state_q == S_SEND && tx_data_read_i) ? gnt_onehot : '0;
    assign ch_done_o       = done_q;
    assign ch_err_o        = errp_q;
    assign tx_data_valid_o = (state_q == S_SEND);
    assign tx_data_in_o    = (state_q == S_SEND) ? ch_data_i[32'(gnt_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign tx_fifo_empty_o = (state_q == S_IDLE) & ~|ch_valid_i;
    assign tx_abort_o      = (state_q == S_ABORT);
    assign gnt_valid_o     = (state_q != S_IDLE);
    assign gnt_id_o        = gnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a bench-side serializer stand-in answers each frame.
module tb_uart_tx_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;

    logic           clk = 1'b0;
    logic           rst_i;
    logic [N-1:0]   ch_valid_i, ch_last_i, ch_abort_i;
    logic [N*DW-1:0] ch_data_i;
    logic [N-1:0]   ch_pop_o, ch_done_o, ch_err_o;
    logic [DW-1:0]  tx_data_in_o;
    logic           tx_data_valid_o, tx_fifo_empty_o, tx_abort_o;
    logic           tx_data_read_i, tx_busy_i, tx_error_i, tx_underrun_i;
    logic           gnt_valid_o;
    logic [1:0]     gnt_id_o;

    int checks = 0;
    int errors = 0;

    int        rem   [N];
    logic [7:0] nxt  [N];
    bit        single[N];

    uart_tx_arbiter #(
        .N_CH(N), .DATA_WIDTH(DW), .MAX_BURST(16), .WDOG_CYCLES(100), .GUARD_CYCLES(2)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ch_valid_i(ch_valid_i), .ch_data_i(ch_data_i), .ch_last_i(ch_last_i),
        .ch_abort_i(ch_abort_i), .ch_pop_o(ch_pop_o), .ch_done_o(ch_done_o),
        .ch_err_o(ch_err_o), .tx_data_in_o(tx_data_in_o), .tx_data_valid_o(tx_data_valid_o),
        .tx_fifo_empty_o(tx_fifo_empty_o), .tx_abort_o(tx_abort_o),
        .tx_data_read_i(tx_data_read_i), .tx_busy_i(tx_busy_i), .tx_error_i(tx_error_i),
        .tx_underrun_i(tx_underrun_i), .gnt_valid_o(gnt_valid_o), .gnt_id_o(gnt_id_o)
    );

    always #5 clk = ~clk;

    // Present each channel's current byte from the bench-side stream model.
    task automatic drive();
        for (int c = 0; c < N; c++) begin
            ch_valid_i[c]         = (rem[c] > 0);
            ch_data_i[c*DW +: DW] = nxt[c];
            ch_last_i[c]          = single[c] ? 1'b1 : (rem[c] == 1);
        end
    endtask

    task automatic consume(input int g);
        rem[g] = rem[g] - 1;
        nxt[g] = nxt[g] + 8'd1;
        drive();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        ch_abort_i = '0; tx_data_read_i = 0; tx_busy_i = 0; tx_error_i = 0; tx_underrun_i = 0;
        for (int c = 0; c < N; c++) begin rem[c] = 0; nxt[c] = 8'h00; single[c] = 1'b0; end
        drive();
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
    endtask

    // Bench serializer: accept one byte, stay busy, then collect the completion pulse.
    task automatic serve_frame(input int busy_len, input bit inject_err,
                               output int g, output logic [7:0] d, output logic [N-1:0] pop,
                               output logic [N-1:0] done, output logic [N-1:0] err, output bit ok);
        ok = 0; g = -1; d = 'x; pop = 'x; done = '0; err = '0;
        for (int i = 0; i < 40 && !tx_data_valid_o; i++) @(negedge clk);
        if (!tx_data_valid_o) return;
        g = int'(gnt_id_o);
        d = tx_data_in_o;
        tx_data_read_i = 1'b1; tx_busy_i = 1'b1;
        #1 pop = ch_pop_o;
        @(negedge clk);
        tx_data_read_i = 1'b0;
        consume(g);
        if (inject_err) begin
            tx_error_i = 1'b1;
            @(negedge clk);
            tx_error_i = 1'b0;
        end
        repeat (busy_len) @(negedge clk);
        tx_busy_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (|ch_done_o || |ch_err_o) begin
                done = ch_done_o; err = ch_err_o; ok = 1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        rst_i = 1'b1;
        @(negedge clk);
        checks++; if (gnt_valid_o !== 1'b0) begin errors++; $display("FAIL reset_gnt_valid got %b exp 0", gnt_valid_o); end
        checks++; if (gnt_id_o !== 2'd0) begin errors++; $display("FAIL reset_gnt_id got %0d exp 0", gnt_id_o); end
        checks++; if (tx_fifo_empty_o !== 1'b1) begin errors++; $display("FAIL reset_fifo_empty got %b exp 1", tx_fifo_empty_o); end
        checks++; if ({tx_data_valid_o, tx_abort_o, ch_pop_o, ch_done_o, ch_err_o, tx_data_in_o} !== '0) begin
            errors++; $display("FAIL reset_outputs got %b %b %b %b %b %h exp all 0",
                               tx_data_valid_o, tx_abort_o, ch_pop_o, ch_done_o, ch_err_o, tx_data_in_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_single();
        int g; logic [7:0] d; logic [N-1:0] pop, done, err; bit ok;
        do_reset();
        rem[1] = 1; nxt[1] = 8'hA5; single[1] = 1; drive();
        #1;
        checks++; if (tx_fifo_empty_o !== 1'b0) begin errors++; $display("FAIL t1_fifo_empty got %b exp 0", tx_fifo_empty_o); end
        @(negedge clk);
        checks++; if ({gnt_valid_o, gnt_id_o} !== 3'b1_01) begin errors++; $display("FAIL t1_grant got v=%b id=%0d exp v=1 id=1", gnt_valid_o, gnt_id_o); end
        serve_frame(3, 0, g, d, pop, done, err, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL t1_timeout got ok=%b exp 1", ok); end
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL t1_data got %h exp a5", d); end
        checks++; if (pop !== 4'b0010) begin errors++; $display("FAIL t1_pop got %b exp 0010", pop); end
        checks++; if ({done, err} !== 8'b0010_0000) begin errors++; $display("FAIL t1_done got done=%b err=%b exp 0010/0000", done, err); end
        // rr_ptr is now 2: with ch0 and ch2 pending, ch2 must win.
        rem[0] = 1; single[0] = 1; rem[2] = 1; single[2] = 1; nxt[2] = 8'h22; drive();
        serve_frame(3, 0, g, d, pop, done, err, ok);
        checks++; if (g !== 2 || d !== 8'h22) begin errors++; $display("FAIL t1_rr_ptr got ch%0d data %h exp ch2 data 22", g, d); end
        serve_frame(3, 0, g, d, pop, done, err, ok);
        checks++; if (g !== 0) begin errors++; $display("FAIL t1_rr_wrap got ch%0d exp ch0", g); end
    endtask

    task automatic test_round_robin();
        int g; logic [7:0] d; logic [N-1:0] pop, done, err; bit ok;
        int exp_g;
        do_reset();
        for (int c = 0; c < N; c++) begin rem[c] = 2; single[c] = 1; nxt[c] = 8'(8'h40 + 8'(c * 16)); end
        drive();
        for (int k = 0; k < 8; k++) begin
            exp_g = k % N;
            serve_frame(2, 0, g, d, pop, done, err, ok);
            checks++;
            if (!ok || g !== exp_g || d !== 8'(8'h40 + 8'(exp_g * 16) + 8'(k / N)) || done !== 4'(1 << exp_g)) begin
                errors++; $display("FAIL t2_frame%0d got ch%0d data %h done %b exp ch%0d", k, g, d, done, exp_g);
            end
        end
        @(negedge clk);
        checks++; if (gnt_valid_o !== 1'b0 || tx_fifo_empty_o !== 1'b1) begin
            errors++; $display("FAIL t2_idle got gnt_valid %b fifo_empty %b exp 0/1", gnt_valid_o, tx_fifo_empty_o);
        end
    endtask

    task automatic test_burst_cap();
        int g; logic [7:0] d; logic [N-1:0] pop, done, err; bit ok;
        int exp_g [22];
        int ch2_idx;
        do_reset();
        for (int k = 0; k < 22; k++) exp_g[k] = 2;
        exp_g[16] = 3; exp_g[17] = 0;
        rem[2] = 20; nxt[2] = 8'h10; drive();
        ch2_idx = 0;
        for (int k = 0; k < 22; k++) begin
            serve_frame(2, 0, g, d, pop, done, err, ok);
            if (k == 0) begin
                rem[0] = 1; single[0] = 1; nxt[0] = 8'h0F;
                rem[3] = 1; single[3] = 1; nxt[3] = 8'h3F; drive();
            end
            checks++;
            if (!ok || g !== exp_g[k] || (g == 2 && d !== 8'(8'h10 + 8'(ch2_idx)))) begin
                errors++; $display("FAIL t3_frame%0d got ch%0d data %h exp ch%0d", k, g, d, exp_g[k]);
            end
            if (g == 2) ch2_idx++;
        end
        checks++; if (gnt_valid_o !== 1'b0 || rem[2] !== 0) begin
            errors++; $display("FAIL t3_release got gnt_valid %b rem %0d exp 0/0", gnt_valid_o, rem[2]);
        end
    endtask

    task automatic test_abort();
        int n;
        logic [N-1:0] done, err;
        do_reset();
        rem[3] = 1; single[3] = 1; nxt[3] = 8'h3C; drive();
        for (int i = 0; i < 10 && !tx_data_valid_o; i++) @(negedge clk);
        checks++; if (gnt_id_o !== 2'd3 || tx_data_valid_o !== 1'b1) begin errors++; $display("FAIL t4_grant got id %0d valid %b exp 3/1", gnt_id_o, tx_data_valid_o); end
        tx_data_read_i = 1; tx_busy_i = 1;
        @(negedge clk);
        tx_data_read_i = 0; consume(3);
        ch_abort_i = 4'b0010;
        @(negedge clk);
        ch_abort_i = '0;
        checks++; if (tx_abort_o !== 1'b0 || gnt_valid_o !== 1'b1) begin errors++; $display("FAIL t4_foreign_abort got abort %b gnt %b exp 0/1", tx_abort_o, gnt_valid_o); end
        ch_abort_i = 4'b1000;
        @(negedge clk);
        ch_abort_i = '0;
        checks++; if (tx_abort_o !== 1'b1) begin errors++; $display("FAIL t4_abort_on got %b exp 1", tx_abort_o); end
        @(negedge clk);
        checks++; if (tx_abort_o !== 1'b1) begin errors++; $display("FAIL t4_abort_hold got %b exp 1", tx_abort_o); end
        tx_busy_i = 0;
        @(negedge clk);
        checks++; if (tx_abort_o !== 1'b0) begin errors++; $display("FAIL t4_abort_off got %b exp 0", tx_abort_o); end
        done = '0; err = '0; n = 0;
        while (n < 10 && !(|ch_done_o || |ch_err_o)) begin @(negedge clk); n++; end
        done = ch_done_o; err = ch_err_o;
        checks++; if ({done, err} !== 8'b0000_1000 || gnt_valid_o !== 1'b0) begin
            errors++; $display("FAIL t4_err got done %b err %b gnt %b exp 0000/1000/0", done, err, gnt_valid_o);
        end
    endtask

    task automatic test_watchdog();
        int n;
        do_reset();
        rem[1] = 1; single[1] = 1; nxt[1] = 8'h77; drive();
        for (int i = 0; i < 10 && !tx_data_valid_o; i++) @(negedge clk);
        tx_data_read_i = 1; tx_busy_i = 1;
        @(negedge clk);
        tx_data_read_i = 0; consume(1);
        n = 0;
        while (!tx_abort_o && n < 300) begin @(negedge clk); n++; end
        checks++; if (n !== 100) begin errors++; $display("FAIL t5_wdog_cycles got %0d exp 100", n); end
        tx_busy_i = 0;
        n = 0;
        while (n < 10 && !(|ch_done_o || |ch_err_o)) begin @(negedge clk); n++; end
        checks++; if ({ch_done_o, ch_err_o} !== 8'b0000_0010) begin errors++; $display("FAIL t5_err got done %b err %b exp 0000/0010", ch_done_o, ch_err_o); end
    endtask

    task automatic test_tx_error();
        int g; logic [7:0] d; logic [N-1:0] pop, done, err; bit ok;
        do_reset();
        rem[0] = 2; nxt[0] = 8'h50; drive();
        serve_frame(3, 1, g, d, pop, done, err, ok);
        checks++; if (!ok || {done, err} !== 8'b0000_0001 || gnt_valid_o !== 1'b0) begin
            errors++; $display("FAIL txerr_first got done %b err %b gnt %b exp 0000/0001/0", done, err, gnt_valid_o);
        end
        serve_frame(3, 0, g, d, pop, done, err, ok);
        checks++; if (!ok || g !== 0 || d !== 8'h51 || {done, err} !== 8'b0001_0000) begin
            errors++; $display("FAIL txerr_second got ch%0d data %h done %b err %b exp ch0 51 0001/0000", g, d, done, err);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        rem[2] = 1; single[2] = 1; nxt[2] = 8'h99; drive();
        for (int i = 0; i < 10 && !tx_data_valid_o; i++) @(negedge clk);
        tx_data_read_i = 1; tx_busy_i = 1;
        @(negedge clk);
        tx_data_read_i = 0;
        repeat (2) @(negedge clk);
        checks++; if (gnt_valid_o !== 1'b1 || gnt_id_o !== 2'd2) begin errors++; $display("FAIL t6_pre got gnt %b id %0d exp 1/2", gnt_valid_o, gnt_id_o); end
        rst_i = 1; tx_busy_i = 0;
        for (int c = 0; c < N; c++) rem[c] = 0;
        drive();
        @(negedge clk);
        checks++; if ({gnt_valid_o, gnt_id_o, tx_data_valid_o, tx_abort_o, ch_pop_o, ch_done_o, ch_err_o} !== '0 || tx_fifo_empty_o !== 1'b1) begin
            errors++; $display("FAIL t6_reset got gnt %b id %0d dv %b ab %b done %b err %b fe %b exp zeros fe=1",
                               gnt_valid_o, gnt_id_o, tx_data_valid_o, tx_abort_o, ch_done_o, ch_err_o, tx_fifo_empty_o);
        end
        for (int c = 0; c < N; c++) begin rem[c] = 1; single[c] = 1; end
        drive();
        rst_i = 0;
        @(negedge clk);
        checks++; if (gnt_valid_o !== 1'b1 || gnt_id_o !== 2'd0) begin errors++; $display("FAIL t6_restart got gnt %b id %0d exp 1/0", gnt_valid_o, gnt_id_o); end
    endtask

    initial begin
        rst_i = 1'b1;
        ch_valid_i = '0; ch_last_i = '0; ch_abort_i = '0; ch_data_i = '0;
        tx_data_read_i = 0; tx_busy_i = 0; tx_error_i = 0; tx_underrun_i = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_burst_cap();
        test_abort();
        test_watchdog();
        test_tx_error();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
